// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 128-bit main-memory bus between icache reads and dcache reads/writebacks.
// One transaction per grant; a watchdog forces a hung grant back to IDLE and latches timeout_o.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 128,
    parameter int STRB_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] ic_read_addr,
    input  logic              ic_read_addr_valid,
    output logic              ic_read_addr_ready,
    output logic [LINE_W-1:0] ic_read_data,
    output logic              ic_read_data_valid,
    input  logic [ADDR_W-1:0] dc_read_addr,
    input  logic              dc_read_addr_valid,
    output logic              dc_read_addr_ready,
    output logic [LINE_W-1:0] dc_read_data,
    output logic              dc_read_data_valid,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic              dc_write_addr_valid,
    output logic              dc_write_addr_ready,
    input  logic [LINE_W-1:0] dc_write_data,
    input  logic [STRB_W-1:0] dc_strobe,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic              mem_read_addr_valid,
    input  logic              mem_read_addr_ready,
    input  logic [LINE_W-1:0] mem_read_data,
    input  logic              mem_read_data_valid,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic              mem_write_addr_valid,
    input  logic              mem_write_addr_ready,
    output logic [LINE_W-1:0] mem_write_data,
    output logic [STRB_W-1:0] mem_strobe,
    output logic              timeout_o,
    output logic [1:0]        state_o
);

    // Handshake: a beat transfers on a clock edge where valid and ready are both high;
    // a requester holds valid (and its payload) stable until that edge.

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GNT_IC_RD = 2'd1;
    localparam logic [1:0] GNT_DC_RD = 2'd2;
    localparam logic [1:0] GNT_DC_WR = 2'd3;

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             last_dc_q, last_dc_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             timeout_q, timeout_d;
    logic             dc_req, grant_ic, gnt_valid, done;

    always_comb begin
        state_d   = state_q;
        last_dc_d = last_dc_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        dc_req    = dc_read_addr_valid | dc_write_addr_valid;
        // IC wins when alone, or on a tie when the DC side was served last
        grant_ic  = ic_read_addr_valid & (~dc_req | last_dc_q);
        gnt_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            GNT_IC_RD: begin
                gnt_valid = ic_read_addr_valid;
                done      = ic_read_addr_valid & mem_read_data_valid;
            end
            GNT_DC_RD: begin
                gnt_valid = dc_read_addr_valid;
                done      = dc_read_addr_valid & mem_read_data_valid;
            end
            GNT_DC_WR: begin
                gnt_valid = dc_write_addr_valid;
                done      = dc_write_addr_valid & mem_write_addr_ready;
            end
            default: ;
        endcase

        if (state_q == IDLE) begin
            wdog_d = '0;
            if (grant_ic) begin
                state_d   = GNT_IC_RD;
                last_dc_d = 1'b0;
            end else if (dc_req) begin
                state_d   = dc_read_addr_valid ? GNT_DC_RD : GNT_DC_WR;
                last_dc_d = 1'b1;
            end
        end else if (done || !gnt_valid) begin
            state_d = IDLE;
            wdog_d  = '0;
        end else if (wdog_q == CNT_LAST) begin
            state_d   = IDLE;
            wdog_d    = '0;
            timeout_d = 1'b1;
        end else begin
            wdog_d = wdog_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            last_dc_q <= 1'b1;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_dc_q <= last_dc_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    // Read data is a broadcast; only the data_valid strobes are steered by the grant.
    always_comb begin
        ic_read_data         = rst_ni ? mem_read_data : '0;
        dc_read_data         = rst_ni ? mem_read_data : '0;
        ic_read_addr_ready   = 1'b0;
        ic_read_data_valid   = 1'b0;
        dc_read_addr_ready   = 1'b0;
        dc_read_data_valid   = 1'b0;
        dc_write_addr_ready  = 1'b0;
        mem_read_addr        = '0;
        mem_read_addr_valid  = 1'b0;
        mem_write_addr       = '0;
        mem_write_addr_valid = 1'b0;
        mem_write_data       = '0;
        mem_strobe           = '0;
        case (state_q)
            GNT_IC_RD: begin
                mem_read_addr       = ic_read_addr;
                mem_read_addr_valid = ic_read_addr_valid;
                ic_read_addr_ready  = mem_read_addr_ready;
                ic_read_data_valid  = ic_read_addr_valid & mem_read_data_valid;
            end
            GNT_DC_RD: begin
                mem_read_addr       = dc_read_addr;
                mem_read_addr_valid = dc_read_addr_valid;
                dc_read_addr_ready  = mem_read_addr_ready;
                dc_read_data_valid  = dc_read_addr_valid & mem_read_data_valid;
            end
            GNT_DC_WR: begin
                mem_write_addr       = dc_write_addr;
                mem_write_addr_valid = dc_write_addr_valid;
                mem_write_data       = dc_write_data;
                mem_strobe           = dc_strobe;
                dc_write_addr_ready  = mem_write_addr_ready;
            end
            default: ;
        endcase
    end

    assign timeout_o = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized and directed transactions checked against a transaction-level
// round-robin model, with a behavioural memory responder and a completion monitor.
module tb_mem_arbiter;

    localparam int K_IC  = 0;
    localparam int K_DCR = 1;
    localparam int K_DCW = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DC_WR  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [31:0]  ic_read_addr = '0;
    logic         ic_read_addr_valid = 1'b0;
    logic         ic_read_addr_ready;
    logic [127:0] ic_read_data;
    logic         ic_read_data_valid;
    logic [31:0]  dc_read_addr = '0;
    logic         dc_read_addr_valid = 1'b0;
    logic         dc_read_addr_ready;
    logic [127:0] dc_read_data;
    logic         dc_read_data_valid;
    logic [31:0]  dc_write_addr = '0;
    logic         dc_write_addr_valid = 1'b0;
    logic         dc_write_addr_ready;
    logic [127:0] dc_write_data = '0;
    logic [15:0]  dc_strobe = '0;
    logic [31:0]  mem_read_addr;
    logic         mem_read_addr_valid;
    logic         mem_read_addr_ready = 1'b0;
    logic [127:0] mem_read_data = '0;
    logic         mem_read_data_valid = 1'b0;
    logic [31:0]  mem_write_addr;
    logic         mem_write_addr_valid;
    logic         mem_write_addr_ready = 1'b0;
    logic [127:0] mem_write_data;
    logic [15:0]  mem_strobe;
    logic         timeout_o;
    logic [1:0]   state_o;

    mem_arbiter #(
        .ADDR_W(32), .LINE_W(128), .STRB_W(16), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ic_read_addr(ic_read_addr), .ic_read_addr_valid(ic_read_addr_valid),
        .ic_read_addr_ready(ic_read_addr_ready), .ic_read_data(ic_read_data),
        .ic_read_data_valid(ic_read_data_valid),
        .dc_read_addr(dc_read_addr), .dc_read_addr_valid(dc_read_addr_valid),
        .dc_read_addr_ready(dc_read_addr_ready), .dc_read_data(dc_read_data),
        .dc_read_data_valid(dc_read_data_valid),
        .dc_write_addr(dc_write_addr), .dc_write_addr_valid(dc_write_addr_valid),
        .dc_write_addr_ready(dc_write_addr_ready), .dc_write_data(dc_write_data),
        .dc_strobe(dc_strobe),
        .mem_read_addr(mem_read_addr), .mem_read_addr_valid(mem_read_addr_valid),
        .mem_read_addr_ready(mem_read_addr_ready), .mem_read_data(mem_read_data),
        .mem_read_data_valid(mem_read_data_valid),
        .mem_write_addr(mem_write_addr), .mem_write_addr_valid(mem_write_addr_valid),
        .mem_write_addr_ready(mem_write_addr_ready), .mem_write_data(mem_write_data),
        .mem_strobe(mem_strobe), .timeout_o(timeout_o), .state_o(state_o)
    );

    logic any_out;
    assign any_out = |{ic_read_addr_ready, ic_read_data, ic_read_data_valid,
                       dc_read_addr_ready, dc_read_data, dc_read_data_valid, dc_write_addr_ready,
                       mem_read_addr, mem_read_addr_valid, mem_write_addr, mem_write_addr_valid,
                       mem_write_data, mem_strobe, timeout_o};

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [177:0] exp_q[$];
    logic [177:0] obs_q[$];
    bit last_dc = 1'b1;      // model: was the DC side granted last?

    // ---------------- memory model knobs ----------------
    int   rd_lat = 2, wr_lat = 0, rd_cnt = 0, wr_cnt = 0;
    bit   rd_busy = 1'b0, mem_mute = 1'b0, use_a5 = 1'b0;
    logic [31:0] rd_addr = '0;

    function automatic logic [127:0] mem_data(input logic [31:0] a);
        if (use_a5) return {16{8'hA5}};
        return {a ^ 32'hA5A5_A5A5, ~a, a, {a[15:0], a[31:16]}};
    endfunction

    function automatic logic [177:0] rec(input int k, input logic [31:0] a,
                                         input logic [127:0] d, input logic [15:0] s);
        return {k[1:0], a, d, s};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk(tag, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- memory responder ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            mem_read_addr_ready  = 1'b0;
            mem_read_data_valid  = 1'b0;
            mem_write_addr_ready = 1'b0;
            if (rd_busy) begin
                if (rd_cnt == 0) begin
                    mem_read_data_valid = 1'b1;
                    mem_read_data       = mem_data(rd_addr);
                    rd_busy             = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if (mem_read_addr_valid) begin
                mem_read_addr_ready = 1'b1;
                rd_addr             = mem_read_addr;
                rd_busy             = !mem_mute;
                rd_cnt              = rd_lat - 1;
            end
            if (mem_write_addr_valid) begin
                if (wr_cnt == 0) begin
                    mem_write_addr_ready = 1'b1;
                    wr_cnt               = wr_lat;
                end else begin
                    wr_cnt--;
                end
            end else begin
                wr_cnt = wr_lat;
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni) begin
                chk("one_rd_valid", ic_read_data_valid & dc_read_data_valid, 0);
                chk("one_mem_chan", mem_read_addr_valid & mem_write_addr_valid, 0);
                if (ic_read_data_valid)
                    obs_q.push_back(rec(K_IC, mem_read_addr, ic_read_data, '0));
                if (dc_read_data_valid)
                    obs_q.push_back(rec(K_DCR, mem_read_addr, dc_read_data, '0));
                if (dc_write_addr_ready)
                    obs_q.push_back(rec(K_DCW, mem_write_addr, mem_write_data, mem_strobe));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ic_read(input logic [31:0] a);
        bit seen = 1'b0;
        @(posedge clk_i); #1;
        ic_read_addr = a;
        ic_read_addr_valid = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i); #2;
            seen = ic_read_data_valid;
        end
        chk("ic_read_done", seen, 1);
        @(posedge clk_i); #1;
        ic_read_addr_valid = 1'b0;
    endtask

    task automatic dc_read(input logic [31:0] a);
        bit seen = 1'b0;
        @(posedge clk_i); #1;
        dc_read_addr = a;
        dc_read_addr_valid = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i); #2;
            seen = dc_read_data_valid;
        end
        chk("dc_read_done", seen, 1);
        @(posedge clk_i); #1;
        dc_read_addr_valid = 1'b0;
    endtask

    task automatic dc_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
        bit seen = 1'b0;
        @(posedge clk_i); #1;
        dc_write_addr = a;
        dc_write_data = d;
        dc_strobe = s;
        dc_write_addr_valid = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i); #2;
            seen = dc_write_addr_ready;
        end
        chk("dc_write_done", seen, 1);
        @(posedge clk_i); #1;
        dc_write_addr_valid = 1'b0;
    endtask

    // Launch a set of simultaneous requests; the model orders completions by round-robin over
    // the pending set, with the DC read ahead of the DC write.
    task automatic run_round(input bit do_ic, input bit do_dcr, input bit do_dcw);
        logic [31:0]  ia, ra, wa;
        logic [127:0] wd;
        logic [15:0]  ws;
        bit p_ic, p_r, p_w;
        ia = $urandom & 32'hFFFF_FFF0;
        ra = $urandom & 32'hFFFF_FFF0;
        wa = $urandom & 32'hFFFF_FFF0;
        wd = {$urandom, $urandom, $urandom, $urandom};
        ws = 16'($urandom_range(1, 16'hFFFF));
        rd_lat = $urandom_range(1, 4);
        wr_lat = $urandom_range(0, 3);
        p_ic = do_ic; p_r = do_dcr; p_w = do_dcw;
        while (p_ic || p_r || p_w) begin
            if (p_ic && (!(p_r || p_w) || last_dc)) begin
                exp_q.push_back(rec(K_IC, ia, mem_data(ia), '0));
                p_ic = 1'b0;
                last_dc = 1'b0;
            end else begin
                if (p_r) begin
                    exp_q.push_back(rec(K_DCR, ra, mem_data(ra), '0));
                    p_r = 1'b0;
                end else begin
                    exp_q.push_back(rec(K_DCW, wa, wd, ws));
                    p_w = 1'b0;
                end
                last_dc = 1'b1;
            end
        end
        fork
            if (do_ic)  ic_read(ia);
            if (do_dcr) dc_read(ra);
            if (do_dcw) dc_write(wa, wd, ws);
        join
        check_sb("round");
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  n;
        bit  seen;
        int  m;
        logic [127:0] wd;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #2;
        chk("rst_held_outputs", any_out, 0);
        rst_ni = 1'b1;
        @(negedge clk_i); #2;
        chk("rst_outputs", any_out, 0);
        chk("rst_state", state_o, ST_IDLE);
        chk("rst_timeout", timeout_o, 0);

        // IC and DC reads together: IC first after reset, then strict alternation
        for (int r = 0; r < 8; r++) run_round(1'b1, 1'b1, 1'b0);

        // Single IC read with fixed pattern data
        use_a5 = 1'b1;
        rd_lat = 3;
        exp_q.push_back(rec(K_IC, 32'h0000_1230, mem_data(32'h0000_1230), '0));
        last_dc = 1'b0;
        fork
            ic_read(32'h0000_1230);
            begin
                @(posedge clk_i);
                @(posedge clk_i);
                @(negedge clk_i); #2;
                chk("ic_fwd_addr", mem_read_addr, 32'h0000_1230);
                chk("ic_fwd_valid", mem_read_addr_valid, 1);
                chk("ic_addr_ready", ic_read_addr_ready, 1);
                chk("dc_addr_ready_masked", dc_read_addr_ready, 0);
                chk("no_write_chan", mem_write_addr_valid, 0);
            end
        join
        use_a5 = 1'b0;
        @(negedge clk_i); #2;
        chk("ic_idle_after", state_o, ST_IDLE);
        check_sb("ic_directed");

        // Writeback then allocate read
        wr_lat = 2;
        rd_lat = 2;
        wd = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(rec(K_DCW, 32'h0000_4A00, wd, 16'hFFFF));
        dc_write(32'h0000_4A00, wd, 16'hFFFF);
        exp_q.push_back(rec(K_DCR, 32'h0000_8A00, mem_data(32'h0000_8A00), '0));
        dc_read(32'h0000_8A00);
        last_dc = 1'b1;
        check_sb("wb_then_alloc");

        // DC read and write together: read first, write after
        run_round(1'b0, 1'b1, 1'b1);
        run_round(1'b1, 1'b1, 1'b1);

        for (int r = 0; r < 12; r++) begin
            m = $urandom_range(1, 7);
            run_round(m[0], m[1], m[2]);
        end

        // Watchdog: memory swallows an IC read; pending DC read wins afterwards
        run_round(1'b0, 1'b1, 1'b0);
        mem_mute = 1'b1;
        @(posedge clk_i); #1;
        ic_read_addr = 32'h0000_7000;
        ic_read_addr_valid = 1'b1;
        dc_read_addr = 32'h0000_9000;
        dc_read_addr_valid = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i); #2;
            if (timeout_o) seen = 1'b1;
            else if (mem_read_addr_valid) n++;
        end
        chk("wdog_fired", seen, 1);
        chk("wdog_granted_cycles", n, 8);
        chk("wdog_idle", state_o, ST_IDLE);
        mem_mute = 1'b0;
        rd_lat = 2;
        exp_q.push_back(rec(K_DCR, 32'h0000_9000, mem_data(32'h0000_9000), '0));
        last_dc = 1'b1;
        @(posedge clk_i); #1;
        ic_read_addr_valid = 1'b0;
        @(negedge clk_i); #2;
        chk("wdog_next_addr", mem_read_addr, 32'h0000_9000);
        chk("wdog_next_ready", dc_read_addr_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (dc_read_data_valid) seen = 1'b1;
            else begin @(negedge clk_i); #2; end
        end
        chk("wdog_dc_served", seen, 1);
        @(posedge clk_i); #1;
        dc_read_addr_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        #2;
        chk("wdog_sticky", timeout_o, 1);
        check_sb("watchdog");
        run_round(1'b1, 1'b0, 1'b0);
        chk("wdog_sticky_late", timeout_o, 1);

        // Asynchronous reset in the middle of a stalled writeback
        @(posedge clk_i); #1;
        wr_lat = 20;
        dc_write_addr = 32'h0000_C000;
        dc_write_data = {4{32'h1234_5678}};
        dc_strobe = 16'h00FF;
        dc_write_addr_valid = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i); #2;
        chk("wr_granted_valid", mem_write_addr_valid, 1);
        chk("wr_granted_state", state_o, ST_DC_WR);
        rst_ni = 1'b0;
        #1;
        chk("midrst_outputs", any_out, 0);
        chk("midrst_state", state_o, ST_IDLE);
        #1;
        dc_write_addr_valid = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i); #2;
        chk("postrst_state", state_o, ST_IDLE);
        chk("postrst_timeout", timeout_o, 0);
        check_sb("midrst");
        last_dc = 1'b1;
        run_round(1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
